sdram_port_arbiter: RTL and testbench

Parametrised multi-channel front end for the SDRAM controller. It accepts CH independent requesters, each with the existing 3-bit call/done handshake ({page read, write, read}), and arbitrates them round-robin or by fixed priority onto the single call/done interface of the SDRAM control path. It latches the winning channel's address and write data, routes read data and the page-read valid strobe back to the owner, and aborts stalled transactions with a watchdog. It sits between the graphic pipeline clients (capture writer, display reader, …) and the SDRAM top.

---
 rtl/sdram_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Multi-channel front end for the SDRAM control path: arbitrates CH call/done
// requesters (round-robin or fixed priority) onto one call/done port, with a watchdog.
module sdram_port_arbiter #(
  parameter int CH       = 4,
  parameter int AW       = 24,
  parameter int DW       = 16,
  parameter int ARB_MODE = 0,
  parameter int TO_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3*CH-1:0]   iCall,
  output logic [3*CH-1:0]   oDone,
  input  logic [AW*CH-1:0]  iAddr,
  input  logic [AW*CH-1:0]  iAddrPage,
  input  logic [DW*CH-1:0]  iData,
  output logic [DW-1:0]     oData,
  output logic [CH-1:0]     oEn,
  output logic [CH-1:0]     oGrant,
  output logic              oErr,
  output logic [2:0]        oMemCall,
  input  logic [2:0]        iMemDone,
  output logic [AW-1:0]     oMemAddr,
  output logic [AW-1:0]     oMemAddrPage,
  output logic [DW-1:0]     oMemData,
  input  logic [DW-1:0]     iMemData,
  input  logic              iMemEn
);

  // Handshake: a client holds its iCall level (and address/data) until it sees a
  // one-cycle oDone on the served bit; oMemCall is held one-hot until the matching
  // iMemDone bit, other iMemDone bits are ignored.
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int WW = (TO_W > 0) ? TO_W : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t            state, stateNext;
  logic [CW-1:0]     rrPtr, rrPtrNext;
  logic [CW-1:0]     owner, ownerNext;
  logic [1:0]        cmd, cmdNext;
  logic [WW-1:0]     wdCnt, wdCntNext;
  logic [3*CH-1:0]   doneNext;
  logic [CH-1:0]     grantNext;
  logic              errNext;
  logic [2:0]        callNext;
  logic [AW-1:0]     addrNext, pageNext;
  logic [DW-1:0]     dataNext;

  logic              anyReq;
  logic [CW-1:0]     winner;
  logic [2:0]        winCall;
  logic [1:0]        winCmd;
  logic              doneHit;
  logic              timeout;

  // Round-robin searches upward from rrPtr with wrap; fixed priority from index 0.
  always_comb begin
    int idx;
    anyReq = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < CH; k++) begin
      idx = (ARB_MODE == 0) ? ((int'(rrPtr) + k) % CH) : k;
      if (!anyReq && (iCall[idx*3 +: 3] != 3'b000)) begin
        anyReq = 1'b1;
        winner = CW'(idx);
      end
    end
  end

  assign winCall = iCall[int'(winner)*3 +: 3];
  assign winCmd  = winCall[0] ? 2'd0 : (winCall[1] ? 2'd1 : 2'd2);
  assign doneHit = |(oMemCall & iMemDone);
  assign timeout = (TO_W > 0) && (&wdCnt);

  always_comb begin
    stateNext = state;
    rrPtrNext = rrPtr;
    ownerNext = owner;
    cmdNext   = cmd;
    wdCntNext = wdCnt;
    doneNext  = '0;
    errNext   = 1'b0;
    grantNext = oGrant;
    callNext  = oMemCall;
    addrNext  = oMemAddr;
    pageNext  = oMemAddrPage;
    dataNext  = oMemData;
    case (state)
      IDLE: begin
        if (anyReq) begin
          grantNext = CH'(1) << winner;
          callNext  = 3'b001 << winCmd;
          addrNext  = iAddr[int'(winner)*AW +: AW];
          pageNext  = iAddrPage[int'(winner)*AW +: AW];
          dataNext  = iData[int'(winner)*DW +: DW];
          rrPtrNext = (int'(winner) == CH - 1) ? '0 : winner + CW'(1);
          ownerNext = winner;
          cmdNext   = winCmd;
          wdCntNext = '0;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        wdCntNext = wdCnt + WW'(1);
        // A done arriving in the timeout cycle still counts as a clean completion.
        if (doneHit || timeout) begin
          callNext = 3'b000;
          doneNext[int'(owner)*3 + int'(cmd)] = 1'b1;
          errNext   = !doneHit;
          stateNext = RELEASE;
        end
      end
      RELEASE: begin
        grantNext = '0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rrPtr        <= '0;
      owner        <= '0;
      cmd          <= '0;
      wdCnt        <= '0;
      oDone        <= '0;
      oErr         <= 1'b0;
      oGrant       <= '0;
      oMemCall     <= 3'b000;
      oMemAddr     <= '0;
      oMemAddrPage <= '0;
      oMemData     <= '0;
    end else begin
      state        <= stateNext;
      rrPtr        <= rrPtrNext;
      owner        <= ownerNext;
      cmd          <= cmdNext;
      wdCnt        <= wdCntNext;
      oDone        <= doneNext;
      oErr         <= errNext;
      oGrant       <= grantNext;
      oMemCall     <= callNext;
      oMemAddr     <= addrNext;
      oMemAddrPage <= pageNext;
      oMemData     <= dataNext;
    end
  end

  assign oData = iMemData;
  assign oEn   = (state == BUSY && cmd == 2'd2 && iMemEn) ? oGrant : '0;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based arbitration model.
module tb_sdram_port_arbiter;
  localparam int CH = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int EW = 3 + 2 + AW + AW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3*CH-1:0]  iCall     = '0;
  logic [AW*CH-1:0] iAddr     = '0;
  logic [AW*CH-1:0] iAddrPage = '0;
  logic [DW*CH-1:0] iData     = '0;
  logic [2:0]       iMemDone  = '0;
  logic [DW-1:0]    iMemData  = '0;
  logic             iMemEn    = 1'b0;

  logic [3*CH-1:0] done0, done1;
  logic [DW-1:0]   data0, data1;
  logic [CH-1:0]   en0, en1, grant0, grant1;
  logic            err0, err1;
  logic [2:0]      call0, call1;
  logic [AW-1:0]   maddr0, maddr1, mpage0, mpage1;
  logic [DW-1:0]   mdata0, mdata1;

  // dut0: round-robin, short watchdog. dut1: fixed priority, default watchdog.
  sdram_port_arbiter #(.CH(CH), .AW(AW), .DW(DW), .ARB_MODE(0), .TO_W(4)) dut0 (
    .clk(clk), .rst(rst), .iCall(iCall), .oDone(done0), .iAddr(iAddr),
    .iAddrPage(iAddrPage), .iData(iData), .oData(data0), .oEn(en0), .oGrant(grant0),
    .oErr(err0), .oMemCall(call0), .iMemDone(iMemDone), .oMemAddr(maddr0),
    .oMemAddrPage(mpage0), .oMemData(mdata0), .iMemData(iMemData), .iMemEn(iMemEn));

  sdram_port_arbiter #(.CH(CH), .AW(AW), .DW(DW), .ARB_MODE(1), .TO_W(12)) dut1 (
    .clk(clk), .rst(rst), .iCall(iCall), .oDone(done1), .iAddr(iAddr),
    .iAddrPage(iAddrPage), .iData(iData), .oData(data1), .oEn(en1), .oGrant(grant1),
    .oErr(err1), .oMemCall(call1), .iMemDone(iMemDone), .oMemAddr(maddr1),
    .oMemAddrPage(mpage1), .oMemData(mdata1), .iMemData(iMemData), .iMemEn(iMemEn));

  bit sel = 1'b0;
  logic [3*CH-1:0] oDone;
  logic [DW-1:0]   oData, oMemData;
  logic [CH-1:0]   oEn, oGrant;
  logic            oErr;
  logic [2:0]      oMemCall;
  logic [AW-1:0]   oMemAddr, oMemAddrPage;
  assign oDone        = sel ? done1  : done0;
  assign oData        = sel ? data1  : data0;
  assign oEn          = sel ? en1    : en0;
  assign oGrant       = sel ? grant1 : grant0;
  assign oErr         = sel ? err1   : err0;
  assign oMemCall     = sel ? call1  : call0;
  assign oMemAddr     = sel ? maddr1 : maddr0;
  assign oMemAddrPage = sel ? mpage1 : mpage0;
  assign oMemData     = sel ? mdata1 : mdata0;

  // Reference model: pending command bits per channel, rotating pointer, expected grants.
  logic [2:0]    req[CH];
  int            rr_ptr;
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iCall = '0; iMemDone = '0; iMemEn = 1'b0;
    for (int i = 0; i < CH; i++) req[i] = 3'b000;
    rr_ptr = 0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic set_call(input int ch, input logic [2:0] c, input logic [AW-1:0] a,
                          input logic [AW-1:0] p, input logic [DW-1:0] d);
    req[ch] = c;
    iCall[ch*3 +: 3]      = c;
    iAddr[ch*AW +: AW]     = a;
    iAddrPage[ch*AW +: AW] = p;
    iData[ch*DW +: DW]     = d;
  endtask

  function automatic int pick_winner(input int mode);
    for (int k = 0; k < CH; k++) begin
      int i;
      i = (mode == 0) ? (rr_ptr + k) % CH : k;
      if (req[i] != 3'b000) return i;
    end
    return -1;
  endfunction

  function automatic int pick_cmd(input logic [2:0] c);
    if (c[0]) return 0;
    if (c[1]) return 1;
    return 2;
  endfunction

  task automatic predict(input int mode);
    int w, c;
    w = pick_winner(mode);
    if (w >= 0) begin
      c = pick_cmd(req[w]);
      exp_q.push_back({3'(w), 2'(c), iAddr[w*AW +: AW], iAddrPage[w*AW +: AW], iData[w*DW +: DW]});
      if (mode == 0) rr_ptr = (w + 1) % CH;
    end
  endtask

  task automatic await_grant(output int w, output int c);
    logic [EW-1:0] e;
    bit seen;
    seen = 1'b0;
    w = 0; c = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (oMemCall != 3'b000) seen = 1'b1;
    end
    check("grant_seen", 64'(seen), 64'd1);
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL model_queue: observed empty expected a prediction");
    end else begin
      e = exp_q.pop_front();
      w = int'(e[EW-1 -: 3]);
      c = int'(e[EW-4 -: 2]);
      check("grant",     64'(oGrant),       64'(1) << w);
      check("mem_call",  64'(oMemCall),     64'(1) << c);
      check("mem_addr",  64'(oMemAddr),     64'(e[DW+AW +: AW]));
      check("mem_page",  64'(oMemAddrPage), 64'(e[DW +: AW]));
      check("mem_data",  64'(oMemData),     64'(e[0 +: DW]));
    end
  endtask

  // Drives the SDRAM side for lat cycles (burst: 16 page-read beats 0..15), then done.
  task automatic complete(input int ch, input int c, input int lat, input bit burst);
    logic [CH-1:0] exp_en;
    for (int i = 0; i < lat; i++) begin
      if (burst) begin
        iMemEn   = (i < 16);
        iMemData = DW'(i);
        iMemDone = 3'b000;
      end else begin
        iMemEn   = 1'($urandom_range(0, 1));
        iMemData = DW'($urandom);
        iMemDone = 3'($urandom_range(0, 7)) & ~(3'b001 << c);
      end
      #1;
      exp_en = (c == 2 && iMemEn) ? (CH'(1) << ch) : '0;
      check("page_en", 64'(oEn), 64'(exp_en));
      check("read_data", 64'(oData), 64'(iMemData));
      tick();
      check("busy_hold", 64'(oMemCall), 64'(1) << c);
      check("busy_no_done", 64'(oDone), 64'd0);
    end
    iMemEn = 1'b0;
    iMemDone = 3'b001 << c;
    tick();
    iMemDone = 3'b000;
    check("done_pulse", 64'(oDone), 64'(1) << (ch*3 + c));
    check("call_drop", 64'(oMemCall), 64'd0);
    check("no_err", 64'(oErr), 64'd0);
    req[ch] = req[ch] & ~(3'b001 << c);
    iCall[ch*3 +: 3] = req[ch];
    tick();
    check("done_one_cycle", 64'(oDone), 64'd0);
    check("grant_release", 64'(oGrant), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int w, c;
    int rr_exp[5];
    bit any;
    rr_exp = '{0, 1, 2, 3, 0};

    // Reset state of both instances.
    do_reset();
    check("rst_done0",  64'(done0),  64'd0);
    check("rst_grant0", 64'(grant0), 64'd0);
    check("rst_call0",  64'(call0),  64'd0);
    check("rst_err0",   64'(err0),   64'd0);
    check("rst_en0",    64'(en0),    64'd0);
    check("rst_addr0",  64'(maddr0), 64'd0);
    check("rst_page0",  64'(mpage0), 64'd0);
    check("rst_data0",  64'(mdata0), 64'd0);
    check("rst_call1",  64'(call1),  64'd0);
    check("rst_grant1", 64'(grant1), 64'd0);

    // Single read on ch2.
    set_call(2, 3'b001, 24'h000123, 24'h0, 16'h0);
    predict(0);
    await_grant(w, c);
    check("single_call",  64'(oMemCall), 64'h1);
    check("single_grant", 64'(oGrant),   64'h4);
    check("single_addr",  64'(oMemAddr), 64'h000123);
    complete(w, c, 8, 1'b0);

    // Multi-bit call: write before page read.
    set_call(0, 3'b110, 24'h00A000, 24'h00B000, 16'hBEEF);
    predict(0);
    await_grant(w, c);
    check("multi_first", 64'(oMemCall), 64'h2);
    complete(w, c, 3, 1'b0);
    predict(0);
    await_grant(w, c);
    check("multi_second", 64'(oMemCall), 64'h4);
    complete(w, c, 5, 1'b0);

    // Round-robin fairness from reset, all channels re-requesting writes.
    do_reset();
    for (int i = 0; i < CH; i++) set_call(i, 3'b010, AW'($urandom), AW'($urandom), DW'($urandom));
    for (int n = 0; n < 5; n++) begin
      predict(0);
      await_grant(w, c);
      check("rr_order", 64'(oGrant), 64'(1) << rr_exp[n]);
      complete(w, c, $urandom_range(0, 6), 1'b0);
      set_call(w, 3'b010, AW'($urandom), AW'($urandom), DW'($urandom));
    end

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      any = 1'b0;
      for (int i = 0; i < CH; i++) begin
        if (req[i] == 3'b000 && $urandom_range(0, 1) == 1)
          set_call(i, 3'($urandom_range(1, 7)), AW'($urandom), AW'($urandom), DW'($urandom));
        if (req[i] != 3'b000) any = 1'b1;
      end
      if (!any)
        set_call($urandom_range(0, CH-1), 3'($urandom_range(1, 7)), AW'($urandom),
                 AW'($urandom), DW'($urandom));
      predict(0);
      await_grant(w, c);
      complete(w, c, $urandom_range(0, 12), 1'b0);
    end

    // Watchdog: no done, then done coinciding with the timeout cycle.
    for (int v = 0; v < 2; v++) begin
      do_reset();
      set_call(3, 3'b001, 24'h0000AA, 24'h0, 16'h0);
      predict(0);
      await_grant(w, c);
      for (int i = 1; i <= 15; i++) begin
        tick();
        check("wd_wait_err", 64'(oErr), 64'd0);
        check("wd_wait_call", 64'(oMemCall), 64'h1);
      end
      if (v == 1) iMemDone = 3'b001;
      tick();
      iMemDone = 3'b000;
      check("wd_err", 64'(oErr), (v == 0) ? 64'd1 : 64'd0);
      check("wd_done", 64'(oDone), 64'(1) << 9);
      check("wd_call", 64'(oMemCall), 64'd0);
      req[3] = 3'b000;
      iCall = '0;
      tick();
      check("wd_err_clear", 64'(oErr), 64'd0);
    end

    // Reset mid-transaction, then spurious SDRAM inputs in IDLE.
    do_reset();
    set_call(1, 3'b010, 24'h000777, 24'h0, 16'h1234);
    predict(0);
    await_grant(w, c);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("midrst_call", 64'(oMemCall), 64'd0);
    check("midrst_done", 64'(oDone), 64'd0);
    check("midrst_grant", 64'(oGrant), 64'd0);
    do_reset();
    tick();
    check("midrst_no_late_done", 64'(oDone), 64'd0);
    iMemDone = 3'b111;
    iMemEn = 1'b1;
    #1;
    check("spur_en", 64'(oEn), 64'd0);
    tick();
    iMemDone = 3'b000;
    iMemEn = 1'b0;
    check("spur_done", 64'(oDone), 64'd0);
    check("spur_call", 64'(oMemCall), 64'd0);
    check("spur_grant", 64'(oGrant), 64'd0);
    check("spur_err", 64'(oErr), 64'd0);

    // Fixed priority on dut1: ch0 keeps re-requesting and starves ch1.
    sel = 1'b1;
    do_reset();
    set_call(0, 3'b010, 24'h000100, 24'h0, 16'h0A0A);
    set_call(1, 3'b010, 24'h000200, 24'h0, 16'h0B0B);
    for (int n = 0; n < 4; n++) begin
      predict(1);
      await_grant(w, c);
      check("fp_ch0_wins", 64'(oGrant), 64'h1);
      complete(w, c, $urandom_range(1, 5), 1'b0);
      if (n < 3) set_call(0, 3'b010, AW'($urandom), 24'h0, DW'($urandom));
    end
    predict(1);
    await_grant(w, c);
    check("fp_ch1_last", 64'(oGrant), 64'h2);
    complete(w, c, 2, 1'b0);

    // Page read routing on ch1 with 16 data beats.
    do_reset();
    set_call(1, 3'b100, 24'h000000, 24'h004000, 16'h0);
    predict(1);
    await_grant(w, c);
    check("page_addr", 64'(oMemAddrPage), 64'h004000);
    complete(w, c, 18, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
